// File: rtl/uart_rx_engine.sv
// UART receiver: synchronised RX input, selectable baud table, 7/8 data bits,
// optional odd/even parity, single stop bit, with ready/parity/framing/overrun flags.
`timescale 1ns/1ps
module uart_rx_engine #(
  parameter int SYNC_STAGES = 2,
  parameter int CLK_HZ      = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [3:0] baud_sel,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam int K_MAX = (CLK_HZ + 150) / 300;
  localparam int CW    = $clog2(K_MAX + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Rounded clocks-per-bit for each baud selection; all entries are constants.
  function automatic logic [CW-1:0] bit_time(input logic [3:0] sel);
    case (sel)
      4'h0:    bit_time = CW'((CLK_HZ + 150) / 300);
      4'h1:    bit_time = CW'((CLK_HZ + 600) / 1200);
      4'h2:    bit_time = CW'((CLK_HZ + 1200) / 2400);
      4'h3:    bit_time = CW'((CLK_HZ + 2400) / 4800);
      4'h4:    bit_time = CW'((CLK_HZ + 4800) / 9600);
      4'h5:    bit_time = CW'((CLK_HZ + 9600) / 19200);
      4'h6:    bit_time = CW'((CLK_HZ + 19200) / 38400);
      4'h7:    bit_time = CW'((CLK_HZ + 28800) / 57600);
      4'h8:    bit_time = CW'((CLK_HZ + 57600) / 115200);
      4'h9:    bit_time = CW'((CLK_HZ + 115200) / 230400);
      4'hA:    bit_time = CW'((CLK_HZ + 230400) / 460800);
      default: bit_time = CW'((CLK_HZ + 460800) / 921600);
    endcase
  endfunction

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] warm;
  logic                   rx_s;
  logic                   warm_ok;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          k_lat;
  logic [CW-1:0]          k_sel;
  logic                   tick;
  logic                   eight_l;
  logic                   pen_l;
  logic                   ohel_l;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   par_err;
  logic [7:0]             data_word;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign warm_ok   = warm[SYNC_STAGES-1];
  assign k_sel     = bit_time(baud_sel);
  assign tick      = (cnt <= CW'(1));
  assign data_word = eight_l ? shift : {1'b0, shift[7:1]};

  // A start is only accepted once the line has genuinely been seen high, so a
  // reset in the middle of a frame cannot lock onto a low data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sync_q  <= '1;
      warm    <= '0;
      armed   <= 1'b0;
      cnt     <= '0;
      k_lat   <= '0;
      eight_l <= 1'b0;
      pen_l   <= 1'b0;
      ohel_l  <= 1'b0;
      bit_cnt <= '0;
      shift   <= '0;
      par_err <= 1'b0;
      rx_data <= 8'h00;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      warm   <= {warm[SYNC_STAGES-2:0], 1'b1};

      if (clr_rdy) begin
        rx_rdy <= 1'b0;
        perr   <= 1'b0;
        ferr   <= 1'b0;
        ovf    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (warm_ok && rx_s) armed <= 1'b1;
          if (armed && !rx_s) begin
            state   <= START;
            cnt     <= k_sel >> 1;
            k_lat   <= k_sel;
            eight_l <= eight;
            pen_l   <= pen;
            ohel_l  <= ohel;
            bit_cnt <= '0;
            shift   <= '0;
            par_err <= 1'b0;
          end
        end
        START: begin
          if (!tick) cnt <= cnt - CW'(1);
          else if (rx_s) state <= IDLE;
          else begin
            state <= DATA;
            cnt   <= k_lat;
          end
        end
        DATA: begin
          if (!tick) cnt <= cnt - CW'(1);
          else begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= k_lat;
            if (bit_cnt == (eight_l ? 3'd7 : 3'd6)) state <= pen_l ? PARITY : STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          if (!tick) cnt <= cnt - CW'(1);
          else begin
            par_err <= rx_s ^ (^data_word) ^ ohel_l;
            cnt     <= k_lat;
            state   <= STOP;
          end
        end
        STOP: begin
          if (!tick) cnt <= cnt - CW'(1);
          else begin
            // Frame load overrides a coincident clr_rdy.
            state   <= IDLE;
            armed   <= rx_s;
            cnt     <= '0;
            rx_data <= data_word;
            perr    <= pen_l & par_err;
            ferr    <= ~rx_s;
            rx_rdy  <= 1'b1;
            ovf     <= rx_rdy & ~clr_rdy;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed frames, a frame-level model
// checked every cycle, and literal expectations after each scenario.
`timescale 1ns/1ps
module tb_uart_rx_engine;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [3:0] baud_sel;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  uart_rx_engine #(.SYNC_STAGES(2), .CLK_HZ(100000000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_sel(baud_sel), .eight(eight),
    .pen(pen), .ohel(ohel), .clr_rdy(clr_rdy), .rx_data(rx_data),
    .rx_rdy(rx_rdy), .perr(perr), .ferr(ferr), .ovf(ovf)
  );

  localparam int BIT_B = 1085;
  localparam int BIT_8 = 8680;

  int   tests;
  int   fails;
  logic check_en;

  logic [7:0] exp_data;
  logic       exp_rdy;
  logic       exp_perr;
  logic       exp_ferr;
  logic       exp_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    exp_data = 8'h00;
    exp_rdy  = 1'b0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  task automatic doReset(input int hold_ns);
    check_en = 1'b0;
    rst = 1'b1;
    #(hold_ns);
    modelReset();
    rst = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
  endtask

  task automatic clearReady();
    @(negedge clk);
    clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_rdy  = 1'b0;
    exp_rdy  = 1'b0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  // Drives one frame on rx; when expect_frame is set the model records the
  // character the receiver must present once the stop bit has been sent.
  task automatic applyStimulus(input logic [7:0] data, input bit is8, input bit p_en,
                               input bit odd, input bit bad_par, input bit stop_lvl,
                               input bit scramble, input bit expect_frame, input int bit_ns);
    logic [7:0] ch;
    logic       pbit;
    int         n;
    logic [3:0] sv_b;
    ch   = is8 ? data : {1'b0, data[6:0]};
    pbit = (odd ? ~(^ch) : (^ch)) ^ bad_par;
    n    = is8 ? 8 : 7;
    eight = is8;
    pen   = p_en;
    ohel  = odd;
    sv_b  = baud_sel;
    @(negedge clk);
    #2;
    rx = 1'b0;
    #(bit_ns);
    if (scramble) begin
      baud_sel = 4'h0;
      eight = ~eight;
      pen   = ~pen;
      ohel  = ~ohel;
    end
    for (int i = 0; i < n; i++) begin
      rx = ch[i];
      #(bit_ns);
    end
    if (p_en) begin
      rx = pbit;
      #(bit_ns);
    end
    if (expect_frame) check_en = 1'b0;
    rx = stop_lvl;
    #(bit_ns);
    if (expect_frame) begin
      exp_ovf  = exp_rdy;
      exp_data = ch;
      exp_perr = p_en && ((($countones(ch) + int'(pbit)) % 2) != (odd ? 1 : 0));
      exp_ferr = (stop_lvl == 1'b0);
      exp_rdy  = 1'b1;
      check_en = 1'b1;
    end
    baud_sel = sv_b;
    eight = is8;
    pen   = p_en;
    ohel  = odd;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] e_data, input logic e_rdy,
                             input logic e_perr, input logic e_ferr, input logic e_ovf);
    @(negedge clk);
    tests++;
    if ({rx_data, rx_rdy, perr, ferr, ovf} !== {e_data, e_rdy, e_perr, e_ferr, e_ovf}) begin
      fails++;
      $display("[TB] FAIL %s: got data=%h rdy=%b perr=%b ferr=%b ovf=%b, expected data=%h rdy=%b perr=%b ferr=%b ovf=%b",
               name, rx_data, rx_rdy, perr, ferr, ovf, e_data, e_rdy, e_perr, e_ferr, e_ovf);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    check_en = 1'b0;
    rst      = 1'b1;
    rx       = 1'b1;
    clr_rdy  = 1'b0;
    baud_sel = 4'hB;
    eight    = 1'b0;
    pen      = 1'b0;
    ohel     = 1'b0;
    modelReset();

    fork
      forever begin
        @(negedge clk);
        if (check_en) begin
          tests++;
          if ({rx_data, rx_rdy, perr, ferr, ovf} !== {exp_data, exp_rdy, exp_perr, exp_ferr, exp_ovf}) begin
            fails++;
            $display("[TB] FAIL cycle_model @%0t: got data=%h rdy=%b perr=%b ferr=%b ovf=%b, expected data=%h rdy=%b perr=%b ferr=%b ovf=%b",
                     $time, rx_data, rx_rdy, perr, ferr, ovf, exp_data, exp_rdy, exp_perr, exp_ferr, exp_ovf);
          end
        end
      end
    join_none

    #33;
    rst = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    checkOutput("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // 7N1 at 921600, clean stop
    applyStimulus(8'h55, 0, 0, 0, 0, 1, 0, 1, BIT_B);
    checkOutput("7N1_55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    clearReady();
    checkOutput("clr_holds_data", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

    // 7N1 with stop held low
    applyStimulus(8'h55, 0, 0, 0, 0, 0, 0, 1, BIT_B);
    checkOutput("7N1_ferr", 8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    clearReady();
    checkOutput("clr_ferr", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

    // 7E1 good and bad parity
    applyStimulus(8'h55, 0, 1, 0, 0, 1, 0, 1, BIT_B);
    checkOutput("7E1_good", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    clearReady();
    applyStimulus(8'h55, 0, 1, 0, 1, 1, 0, 1, BIT_B);
    checkOutput("7E1_bad", 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    clearReady();

    // 8O1 at 115200, overrun
    baud_sel = 4'h8;
    applyStimulus(8'hA3, 1, 1, 1, 0, 1, 0, 1, BIT_8);
    checkOutput("8O1_A3", 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h3C, 1, 1, 1, 0, 1, 0, 1, BIT_8);
    checkOutput("8O1_ovf", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    clearReady();
    checkOutput("clr_ovf", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    // configuration changed mid-frame must not disturb it
    baud_sel = 4'hB;
    applyStimulus(8'hC6, 1, 0, 0, 0, 1, 1, 1, BIT_B);
    checkOutput("cfg_latched", 8'hC6, 1'b1, 1'b0, 1'b0, 1'b0);
    clearReady();

    // 60 ns glitch is a false start
    @(negedge clk);
    #2;
    rx = 1'b0;
    #60;
    rx = 1'b1;
    #(3 * BIT_B);
    checkOutput("glitch", 8'hC6, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset early in data bit 4 of 8'hE5 (bit 4 low, bits 5..7 high)
    fork
      applyStimulus(8'hE5, 1, 0, 0, 0, 1, 0, 0, BIT_B);
      begin
        @(negedge clk);
        #2;
        #5530;
        doReset(20);
      end
    join
    repeat (200) @(negedge clk);
    checkOutput("rst_midframe", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5A, 1, 0, 0, 0, 1, 0, 1, BIT_B);
    checkOutput("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    clearReady();

    // back-to-back frames
    applyStimulus(8'h81, 1, 0, 0, 0, 1, 0, 1, BIT_B);
    applyStimulus(8'h7E, 1, 0, 0, 0, 1, 0, 1, BIT_B);
    checkOutput("back_to_back", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1);
    clearReady();
    checkOutput("final_clr", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
